// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter width; a one-bit adder still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: streams operands LSB-first through one fa_cell.
// Optional SERIAL_ADDER_SUB_EN adds a sub input for A - B.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] b_load;
    logic             carry;
    logic             carry_load;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic             load_c;
    logic             shift_c;
    logic             last_c;

    // Subtraction is A + ~B + 1; cin is ignored in that mode.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~B : B;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = B;
    assign carry_load = cin;
`endif

    fa_cell u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB so the LSB lands in bit 0 after WIDTH shifts.
    assign s_next = (s_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (cnt == LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load_c  = 1'b0;
        shift_c = 1'b0;
        last_c  = 1'b0;
        case (state)
            IDLE:  load_c = start;
            SHIFT: begin
                shift_c = 1'b1;
                last_c  = (cnt == LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= last_c;
            if (load_c) begin
                a_sr  <= A;
                b_sr  <= b_load;
                carry <= carry_load;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (shift_c) begin
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                s_sr  <= s_next;
                carry <= fa_co;
                cnt   <= cnt + CW'(1);
                if (last_c) begin
                    sum  <= s_next;
                    cout <= fa_co;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n === 1'b1 && done === 1'b1) done_cnt++;

    // Called at a negedge; returns at the negedge where done is high.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [8:0] exp, input string name);
        int lat;
        A = a; B = b; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = 8'($urandom); B = 8'($urandom); cin = 1'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s busy: got %b expected 1", name, busy);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 8) begin
            errors++; $display("FAIL %s latency: got %0d expected 8", name, lat);
        end
        checks++;
        if ({cout, sum} !== exp) begin
            errors++; $display("FAIL %s result: got %h expected %h", name, {cout, sum}, exp);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL %s busy at done: got %b expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b1; A = 8'hA5; B = 8'h5A; cin = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cout, sum} !== 11'h000) begin
            errors++; $display("FAIL reset async: got busy=%b done=%b cout=%b sum=%h expected all 0",
                               busy, done, cout, sum);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, cout, sum} !== 11'h000) begin
            errors++; $display("FAIL reset held: got busy=%b done=%b cout=%b sum=%h expected all 0",
                               busy, done, cout, sum);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_op(8'h3C, 8'h05, 1'b0, 9'h041, "basic");
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL basic done width: got %b expected 0", done);
        end
        checks++;
        if ({cout, sum} !== 9'h041) begin
            errors++; $display("FAIL basic hold: got %h expected 041", {cout, sum});
        end
    endtask

    task automatic test_back_to_back();
        run_op(8'hFF, 8'h01, 1'b0, 9'h100, "carry_chain");
        run_op(8'hFF, 8'hFF, 1'b1, 9'h1FF, "back_to_back");
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int lat;
        A = 8'h10; B = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        A = 8'h01; B = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_ignore busy: got %b expected 1", busy);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if ({cout, sum} !== 9'h030 || lat >= 40) begin
            errors++; $display("FAIL busy_ignore result: got %h expected 030", {cout, sum});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int d0;
        d0 = done_cnt;
        A = 8'h77; B = 8'h11; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cout, sum} !== 11'h000) begin
            errors++; $display("FAIL reset_mid outputs: got busy=%b done=%b cout=%b sum=%h expected all 0",
                               busy, done, cout, sum);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (done_cnt !== d0) begin
            errors++; $display("FAIL reset_mid done pulses: got %0d expected %0d", done_cnt, d0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h12, 8'h34, 1'b0, 9'h046, "after_reset");
        @(negedge clk);
    endtask

    task automatic test_sweep();
        int d0;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        d0 = done_cnt;
        run_op(8'h00, 8'h00, 1'b0, 9'h000, "zero");
        run_op(8'h80, 8'h80, 1'b0, 9'h100, "msb_carry");
        for (int i = 0; i < 200; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            ci = 1'($urandom);
            run_op(a, b, ci, {1'b0, a} + {1'b0, b} + {8'h00, ci}, "sweep");
        end
        @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 202) begin
            errors++; $display("FAIL sweep done count: got %0d expected 202", done_cnt - d0);
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        sub = 1'b1;
        run_op(8'h10, 8'h01, 1'b0, 9'h10F, "sub_no_borrow");
        run_op(8'h01, 8'h02, 1'b1, 9'h0FF, "sub_borrow");
        sub = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        test_reset();
        test_basic();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_op();
        test_sweep();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
